// File: rtl/sccb_cfg_sequencer_if.sv
// rtl/sccb_cfg_sequencer_if.sv - SCCB transaction bus between the configuration sequencer and CoreSCCB
interface sccb_cfg_sequencer_if;
  logic       sccb_start;
  logic       sccb_rw;
  logic [7:0] sccb_ip_addr;
  logic [7:0] sccb_sub_addr;
  logic [7:0] sccb_data_in;
  logic [7:0] sccb_data_out;
  logic       sccb_done;

  modport master (
    output sccb_start, sccb_rw, sccb_ip_addr, sccb_sub_addr, sccb_data_in,
    input  sccb_data_out, sccb_done
  );

  modport slave (
    input  sccb_start, sccb_rw, sccb_ip_addr, sccb_sub_addr, sccb_data_in,
    output sccb_data_out, sccb_done
  );
endinterface

// File: rtl/sccb_cfg_sequencer.sv
// rtl/sccb_cfg_sequencer.sv - table-driven SCCB register configuration engine with bit-tick divider
// Optional read-back verification of every write: define SCCB_CFG_VERIFY_EN.
module sccb_cfg_sequencer #(
  parameter int         CLK_FREQ   = 8_000_000,
  parameter int         SCCB_FREQ  = 100_000,
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         DEPTH      = 64,
  parameter int         DELAY_UNIT = CLK_FREQ / 1000,
  parameter int         TIMEOUT    = 64,
  parameter int         MAX_RETRY  = 3,
  localparam int        IDX_W      = $clog2(DEPTH)
) (
  input  logic             PCLK,
  input  logic             PRESETN,
  input  logic             cfg_start,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [IDX_W-1:0] err_index,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [15:0]      tbl_data,
  output logic             SCCB_CLK,
  output logic             SCCB_MID_PULSE,
  sccb_cfg_sequencer_if.master sccb
);

  localparam int HALF  = CLK_FREQ / SCCB_FREQ / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int RT_W  = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_WRITE, ST_GAP, ST_DELAY, ST_FAIL, ST_DONE, ST_ERROR
`ifdef SCCB_CFG_VERIFY_EN
    , ST_VGAP, ST_VERIFY
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q;
  logic             sccb_clk_q, mid_q;
  logic [IDX_W-1:0] index_q, err_index_q;
  logic [RT_W-1:0]  retry_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [31:0]      dly_cnt_q, dly_tgt_q;
  logic [7:0]       ip_q, sub_q, data_q;
  logic             done_q, err_q;
  logic             start_o, busy_o;

  wire tick      = mid_q;
  wire is_end    = (tbl_data == 16'hFFFF);
  wire is_dly    = (tbl_data[15:8] == 8'hFF);
  wire to_expire = (to_cnt_q == TO_W'(TIMEOUT - 1));
  wire last_idx  = (index_q == IDX_W'(DEPTH - 1));
  wire retry_ok  = ((retry_q + 1'b1) < RT_W'(MAX_RETRY));

  // Mid-pulse lands half-way through the low phase, one pulse per SCCB_CLK period.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      div_cnt_q  <= '0;
      sccb_clk_q <= 1'b0;
      mid_q      <= 1'b0;
    end else begin
      mid_q <= (div_cnt_q == DIV_W'(HALF / 2)) && !sccb_clk_q;
      if (div_cnt_q == DIV_W'(HALF - 1)) begin
        div_cnt_q  <= '0;
        sccb_clk_q <= ~sccb_clk_q;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cfg_start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = is_end ? ST_DONE : (is_dly ? ST_DELAY : ST_WRITE);
      ST_WRITE: begin
        // A done sampled on the expiring tick still counts as success.
        if (tick) begin
`ifdef SCCB_CFG_VERIFY_EN
          if (sccb.sccb_done) state_d = ST_VGAP;
`else
          if (sccb.sccb_done) state_d = ST_GAP;
`endif
          else if (to_expire) state_d = ST_FAIL;
        end
      end
`ifdef SCCB_CFG_VERIFY_EN
      ST_VGAP:   if (tick) state_d = ST_VERIFY;
      ST_VERIFY: begin
        if (tick) begin
          if (sccb.sccb_done) state_d = (sccb.sccb_data_out == data_q) ? ST_GAP : ST_FAIL;
          else if (to_expire) state_d = ST_FAIL;
        end
      end
`endif
      ST_GAP:    if (tick) state_d = last_idx ? ST_DONE : ST_FETCH;
      ST_DELAY:  if (dly_cnt_q >= dly_tgt_q) state_d = last_idx ? ST_DONE : ST_FETCH;
      ST_FAIL:   if (tick) state_d = retry_ok ? ST_DECODE : ST_ERROR;
      ST_DONE:   state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_o = 1'b0;
    busy_o  = 1'b1;
    case (state_q)
      ST_WRITE:  start_o = 1'b1;
`ifdef SCCB_CFG_VERIFY_EN
      ST_VERIFY: start_o = 1'b1;
`endif
      ST_IDLE, ST_DONE, ST_ERROR: busy_o = 1'b0;
      default: ;
    endcase
  end

`ifdef SCCB_CFG_VERIFY_EN
  logic rw_q;
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)                                   rw_q <= 1'b0;
    else if (state_q == ST_DECODE)                  rw_q <= 1'b0;
    else if (state_q == ST_WRITE && state_d == ST_VGAP) rw_q <= 1'b1;
  end
  assign sccb.sccb_rw = rw_q;
`else
  logic unused_data_out;
  assign unused_data_out = ^sccb.sccb_data_out;
  assign sccb.sccb_rw    = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      index_q     <= '0;
      err_index_q <= '0;
      retry_q     <= '0;
      to_cnt_q    <= '0;
      dly_cnt_q   <= '0;
      dly_tgt_q   <= '0;
      ip_q        <= 8'h00;
      sub_q       <= 8'h00;
      data_q      <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (cfg_start) begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          index_q <= '0;
          retry_q <= '0;
        end
        ST_DECODE: begin
          to_cnt_q  <= '0;
          dly_cnt_q <= '0;
          dly_tgt_q <= 32'(tbl_data[7:0]) * 32'(DELAY_UNIT);
          if (!is_end && !is_dly) begin
            ip_q   <= DEV_ADDR;
            sub_q  <= tbl_data[15:8];
            data_q <= tbl_data[7:0];
          end
        end
        ST_WRITE: begin
          if (tick) to_cnt_q <= to_cnt_q + 1'b1;
`ifdef SCCB_CFG_VERIFY_EN
          if (state_d == ST_VGAP) begin
            ip_q     <= DEV_ADDR | 8'h01;
            to_cnt_q <= '0;
          end
`endif
        end
`ifdef SCCB_CFG_VERIFY_EN
        ST_VERIFY: if (tick) to_cnt_q <= to_cnt_q + 1'b1;
`endif
        ST_DELAY: dly_cnt_q <= dly_cnt_q + 1;
        ST_FAIL: if (tick) begin
          retry_q <= retry_q + 1'b1;
          if (state_d == ST_ERROR) err_index_q <= index_q;
        end
        default: ;
      endcase
      if ((state_q == ST_GAP || state_q == ST_DELAY) && state_d == ST_FETCH) begin
        index_q <= index_q + 1'b1;
        retry_q <= '0;
      end
      if (state_d == ST_DONE)  done_q <= 1'b1;
      if (state_d == ST_ERROR) err_q  <= 1'b1;
    end
  end

  assign SCCB_CLK           = sccb_clk_q;
  assign SCCB_MID_PULSE     = mid_q;
  assign tbl_addr           = index_q;
  assign err_index          = err_index_q;
  assign cfg_busy           = busy_o;
  assign cfg_done           = done_q;
  assign cfg_err            = err_q;
  assign sccb.sccb_start    = start_o;
  assign sccb.sccb_ip_addr  = ip_q;
  assign sccb.sccb_sub_addr = sub_q;
  assign sccb.sccb_data_in  = data_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// tb/tb_sccb_cfg_sequencer.sv - scoreboard bench for sccb_cfg_sequencer with a CoreSCCB responder model
module tb_sccb_cfg_sequencer;
  localparam int         DEPTH   = 4;
  localparam int         TOUT    = 24;
  localparam logic [7:0] DEV     = 8'h42;
  localparam int         BUDGET  = 20000;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [1:0]  err_index, tbl_addr;
  logic [15:0] tbl_data = 16'h0000;
  logic        SCCB_CLK, SCCB_MID_PULSE;
  logic [15:0] tbl_mem [DEPTH];

  sccb_cfg_sequencer_if sif();

  sccb_cfg_sequencer #(
    .CLK_FREQ(8_000_000), .SCCB_FREQ(100_000), .DEV_ADDR(DEV), .DEPTH(DEPTH),
    .DELAY_UNIT(10), .TIMEOUT(TOUT), .MAX_RETRY(3)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .cfg_start(cfg_start), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .err_index(err_index), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .SCCB_CLK(SCCB_CLK), .SCCB_MID_PULSE(SCCB_MID_PULSE), .sccb(sif)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) tbl_data <= tbl_mem[tbl_addr];

  int total = 0;
  int bad = 0;
  logic [24:0] exp_q[$];
  int need [256];
  int att [256];
  int rdc [256];
  int rd_bad [256];
  logic [7:0] last_wr [256];
  int ack_ticks = 2;
  int rw_seen = 0;
  int gap_ticks = 99;
  int tcnt = 0;
  bit cur_ack = 1'b0;
  bit prev_start = 1'b0;

  initial begin
    sif.sccb_done = 1'b0;
    sif.sccb_data_out = 8'h00;
  end

  // CoreSCCB stand-in: acks after ack_ticks ticks, checks each request against the scoreboard.
  always @(negedge PCLK) begin
    logic [24:0] got, want;
    if (!PRESETN) begin
      prev_start = 1'b0;
      tcnt = 0;
      sif.sccb_done = 1'b0;
    end else begin
      if (sif.sccb_start && !prev_start) begin
        got = {sif.sccb_rw, sif.sccb_ip_addr, sif.sccb_sub_addr, sif.sccb_data_in};
        if (sif.sccb_rw) rw_seen++;
        total++;
        if (gap_ticks < 1) begin
          bad++;
          $display("FAIL start_gap ticks_low=%0d want>=1", gap_ticks);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL txn_unexpected got=%h want=none", got);
        end else begin
          want = exp_q.pop_front();
          if (want[24]) begin
            got[7:0] = 8'h00;
            want[7:0] = 8'h00;
          end
          if (got !== want) begin
            bad++;
            $display("FAIL txn_fields got=%h want=%h", got, want);
          end
        end
        gap_ticks = 0;
        tcnt = 0;
        if (!sif.sccb_rw) begin
          att[sif.sccb_sub_addr]++;
          last_wr[sif.sccb_sub_addr] = sif.sccb_data_in;
          cur_ack = att[sif.sccb_sub_addr] >= need[sif.sccb_sub_addr];
        end else begin
          rdc[sif.sccb_sub_addr]++;
          sif.sccb_data_out = (rdc[sif.sccb_sub_addr] <= rd_bad[sif.sccb_sub_addr]) ?
                              last_wr[sif.sccb_sub_addr] - 8'd1 : last_wr[sif.sccb_sub_addr];
          cur_ack = 1'b1;
        end
      end
      if (sif.sccb_start) begin
        if (SCCB_MID_PULSE) tcnt++;
        sif.sccb_done = cur_ack && (tcnt >= ack_ticks);
      end else begin
        sif.sccb_done = 1'b0;
        if (SCCB_MID_PULSE) gap_ticks++;
      end
      prev_start = sif.sccb_start;
    end
  end

  task automatic reset_model();
    for (int i = 0; i < 256; i++) begin
      need[i] = 1;
      att[i] = 0;
      rdc[i] = 0;
      rd_bad[i] = 0;
    end
    exp_q.delete();
    rw_seen = 0;
  endtask

  task automatic set_table(input logic [15:0] e0, e1, e2, e3);
    tbl_mem[0] = e0;
    tbl_mem[1] = e1;
    tbl_mem[2] = e2;
    tbl_mem[3] = e3;
  endtask

  // Push a write, plus its read-back when verification is built in.
  task automatic exp_write(input logic [7:0] sub, input logic [7:0] dat, input bit verified);
    exp_q.push_back({1'b0, DEV, sub, dat});
`ifdef SCCB_CFG_VERIFY_EN
    if (verified) exp_q.push_back({1'b1, DEV | 8'h01, sub, 8'h00});
`else
    if (verified) ;
`endif
  endtask

  task automatic pulse_start();
    @(negedge PCLK);
    cfg_start = 1'b1;
    @(negedge PCLK);
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (cfg_busy && n <= BUDGET) begin
      @(negedge PCLK);
      n++;
    end
    total++;
    if (cfg_busy) begin
      bad++;
      $display("FAIL %s_timeout busy=%0d after %0d cycles want=0", name, cfg_busy, n);
    end
  endtask

  task automatic check_end(input string name, input bit want_done, input bit want_err);
    total++;
    if ({cfg_busy, cfg_done, cfg_err} !== {1'b0, want_done, want_err}) begin
      bad++;
      $display("FAIL %s_status busy/done/err=%b%b%b want=0%b%b", name, cfg_busy, cfg_done, cfg_err, want_done, want_err);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_txns left=%0d want=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    total++;
    if ({SCCB_CLK, SCCB_MID_PULSE, sif.sccb_start, sif.sccb_rw} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000", {SCCB_CLK, SCCB_MID_PULSE, sif.sccb_start, sif.sccb_rw});
    end
    total++;
    if ({sif.sccb_ip_addr, sif.sccb_sub_addr, sif.sccb_data_in, tbl_addr, err_index} !== 28'h0) begin
      bad++;
      $display("FAIL reset_fields got=%h want=0", {sif.sccb_ip_addr, sif.sccb_sub_addr, sif.sccb_data_in, tbl_addr, err_index});
    end
    total++;
    if ({cfg_busy, cfg_done, cfg_err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_status got=%b want=000", {cfg_busy, cfg_done, cfg_err});
    end
  endtask

  task automatic test_divider();
    int c = 0;
    int pulses = 0;
    int misplaced = 0;
    bit prev_clk = SCCB_CLK;
    bit prev_mid = 1'b0;
    while (!(SCCB_CLK && !prev_clk) && c < 200) begin
      prev_clk = SCCB_CLK;
      @(negedge PCLK);
      c++;
    end
    c = 0;
    do begin
      prev_clk = SCCB_CLK;
      @(negedge PCLK);
      c++;
    end while (!(SCCB_CLK && !prev_clk) && c < 200);
    total++;
    if (c != 80) begin
      bad++;
      $display("FAIL div_period got=%0d want=80", c);
    end
    for (int i = 0; i < 160; i++) begin
      @(negedge PCLK);
      if (SCCB_MID_PULSE) begin
        pulses++;
        if (SCCB_CLK || prev_mid) misplaced++;
      end
      prev_mid = SCCB_MID_PULSE;
    end
    total++;
    if (pulses != 2 || misplaced != 0) begin
      bad++;
      $display("FAIL div_mid_pulse count=%0d misplaced=%0d want=2/0", pulses, misplaced);
    end
  endtask

  task automatic test_basic();
    reset_model();
    set_table(16'h1280, 16'h1100, 16'hFFFF, 16'h0000);
    ack_ticks = 20;
    exp_write(8'h12, 8'h80, 1);
    exp_write(8'h11, 8'h00, 1);
    pulse_start();
    total++;
    if (cfg_busy !== 1'b1) begin
      bad++;
      $display("FAIL start_latency busy=%b want=1", cfg_busy);
    end
    repeat (300) @(negedge PCLK);
    cfg_start = 1'b1;
    @(negedge PCLK);
    cfg_start = 1'b0;
    wait_idle("basic");
    check_end("basic", 1, 0);
  endtask

  task automatic test_delay();
    int c = 1;
    reset_model();
    set_table(16'hFF05, 16'hFF00, 16'h1280, 16'hFFFF);
    ack_ticks = 2;
    exp_write(8'h12, 8'h80, 1);
    @(negedge PCLK);
    cfg_start = 1'b1;
    @(negedge PCLK);
    cfg_start = 1'b0;
    while (!sif.sccb_start && c < 500) begin
      @(negedge PCLK);
      c++;
    end
    total++;
    if (c != 59) begin
      bad++;
      $display("FAIL delay_start_cycles got=%0d want=59", c);
    end
    wait_idle("delay");
    check_end("delay", 1, 0);
  endtask

  task automatic test_timeout_retry();
    reset_model();
    set_table(16'h1280, 16'h1100, 16'h1355, 16'hFFFF);
    ack_ticks = 2;
    need[8'h13] = 99;
    exp_write(8'h12, 8'h80, 1);
    exp_write(8'h11, 8'h00, 1);
    for (int i = 0; i < 3; i++) exp_write(8'h13, 8'h55, 0);
    pulse_start();
    wait_idle("never_ack");
    check_end("never_ack", 0, 1);
    total++;
    if (err_index !== 2'd2) begin
      bad++;
      $display("FAIL err_index got=%0d want=2", err_index);
    end
    reset_model();
    need[8'h13] = 3;
    exp_write(8'h12, 8'h80, 1);
    exp_write(8'h11, 8'h00, 1);
    exp_write(8'h13, 8'h55, 0);
    exp_write(8'h13, 8'h55, 0);
    exp_write(8'h13, 8'h55, 1);
    pulse_start();
    wait_idle("third_ack");
    check_end("third_ack", 1, 0);
  endtask

  task automatic test_done_vs_timeout();
    reset_model();
    set_table(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    ack_ticks = TOUT;
    exp_write(8'h12, 8'h80, 1);
    pulse_start();
    wait_idle("ack_on_last_tick");
    check_end("ack_on_last_tick", 1, 0);
    reset_model();
    ack_ticks = TOUT + 1;
    for (int i = 0; i < 3; i++) exp_write(8'h12, 8'h80, 0);
    pulse_start();
    wait_idle("ack_too_late");
    check_end("ack_too_late", 0, 1);
    total++;
    if (err_index !== 2'd0) begin
      bad++;
      $display("FAIL late_err_index got=%0d want=0", err_index);
    end
  endtask

  task automatic test_verify();
    reset_model();
    set_table(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    ack_ticks = 2;
    rd_bad[8'h12] = 1;
`ifdef SCCB_CFG_VERIFY_EN
    exp_write(8'h12, 8'h80, 1);
    exp_write(8'h12, 8'h80, 1);
`else
    exp_write(8'h12, 8'h80, 1);
`endif
    pulse_start();
    wait_idle("verify");
    check_end("verify", 1, 0);
`ifndef SCCB_CFG_VERIFY_EN
    total++;
    if (rw_seen != 0) begin
      bad++;
      $display("FAIL no_read_txns got=%0d want=0", rw_seen);
    end
`endif
  endtask

  task automatic test_no_end_marker();
    reset_model();
    set_table(16'h1201, 16'h1302, 16'h1403, 16'h1504);
    ack_ticks = 2;
    exp_write(8'h12, 8'h01, 1);
    exp_write(8'h13, 8'h02, 1);
    exp_write(8'h14, 8'h03, 1);
    exp_write(8'h15, 8'h04, 1);
    pulse_start();
    wait_idle("no_end_marker");
    check_end("no_end_marker", 1, 0);
  endtask

  task automatic test_reset_mid();
    int c = 0;
    reset_model();
    set_table(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    ack_ticks = 20;
    exp_write(8'h12, 8'h80, 1);
    pulse_start();
    while (!sif.sccb_start && c < 500) begin
      @(negedge PCLK);
      c++;
    end
    total++;
    if (!sif.sccb_start) begin
      bad++;
      $display("FAIL reset_mid_no_start start=%b want=1", sif.sccb_start);
    end
    repeat (200) @(negedge PCLK);
    #2 PRESETN = 1'b0;
    #1;
    total++;
    if ({sif.sccb_start, sif.sccb_rw, SCCB_CLK, SCCB_MID_PULSE, cfg_busy, cfg_done, cfg_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_mid_ctrl got=%b want=0000000",
               {sif.sccb_start, sif.sccb_rw, SCCB_CLK, SCCB_MID_PULSE, cfg_busy, cfg_done, cfg_err});
    end
    total++;
    if ({sif.sccb_ip_addr, sif.sccb_sub_addr, sif.sccb_data_in, tbl_addr, err_index} !== 28'h0) begin
      bad++;
      $display("FAIL reset_mid_fields got=%h want=0", {sif.sccb_ip_addr, sif.sccb_sub_addr, sif.sccb_data_in, tbl_addr, err_index});
    end
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
    reset_model();
  endtask

  initial begin
    reset_model();
    set_table(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge PCLK);
    test_reset();
    PRESETN = 1'b1;
    test_divider();
    test_basic();
    test_delay();
    test_timeout_retry();
    test_done_vs_timeout();
    test_verify();
    test_no_end_marker();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
